// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared ALU between two requesters.
// Accept to response valid takes EXEC_CYC+1 cycles; minimum issue interval is EXEC_CYC+2.
// Holding response ready low stalls the response indefinitely, and neither request is accepted meanwhile.
module alu_arbiter #(
    parameter int EXEC_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    input  logic        req1_sub,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_status,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_opcode,
    output logic        alu_sub,
    output logic        alu_cin,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        sub;
    } alu_req_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYC - 1);

    state_t     state;
    logic       last_grant;
    logic       owner;
    logic [3:0] cnt;

    logic       win0;
    logic       win1;
    logic       req_hs;
    alu_req_t   win_req;

    logic [31:0] eff_b;
    logic        is_add;
    logic [3:0]  status_nxt;

    // On a tie the requester not granted last time wins.
    always_comb begin
        win1 = req1_valid && (!req0_valid || !last_grant);
        win0 = req0_valid && !win1;
    end

    // Gated by rst_n so no ready leaks out while reset is held.
    assign req0_ready = rst_n && (state == IDLE) && win0;
    assign req1_ready = rst_n && (state == IDLE) && win1;
    assign req_hs     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_comb begin
        if (win1) begin
            win_req = '{a: req1_a, b: req1_b, op: req1_op, sub: req1_sub};
        end else begin
            win_req = '{a: req0_a, b: req0_b, op: req0_op, sub: req0_sub};
        end
    end

    // Flags are derived from the operands the ALU actually sees.
    always_comb begin
        eff_b         = alu_sub ? ~alu_b : alu_b;
        is_add        = (alu_opcode == 3'b000);
        status_nxt[3] = is_add && (alu_a[31] == eff_b[31]) && (alu_result[31] != alu_a[31]);
        status_nxt[2] = is_add && alu_cout;
        status_nxt[1] = alu_result[31];
        status_nxt[0] = (alu_result == 32'd0);
    end

    assign alu_cin = 1'b0;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= 4'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_opcode <= 3'd0;
            alu_sub    <= 1'b0;
            rsp_result <= 32'd0;
            rsp_status <= 4'd0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        alu_a      <= win_req.a;
                        alu_b      <= win_req.b;
                        alu_opcode <= win_req.op;
                        alu_sub    <= win_req.sub;
                        owner      <= win1;
                        last_grant <= win1;
                        cnt        <= CNT_LOAD;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_status <= status_nxt;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: scoreboard on an EXEC_CYC=1 instance, directed latency/reset checks on an EXEC_CYC=3 instance.
module tb_alu_arbiter;

    localparam int EC  = 1;
    localparam int EC3 = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        sub;
    } op_t;

    typedef struct packed {
        op_t         o;
        logic        known;
        logic [31:0] er;
        logic [3:0]  es;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Environment ALU: combinational, driven by the DUT's registered operands.
    function automatic logic [32:0] alu_env(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic sub);
        logic [32:0] s;
        s = '0;
        case (op)
            3'd0: s = {1'b0, a} + {1'b0, (sub ? ~b : b)} + 33'(sub);
            3'd1: s = {1'b0, a ^ b};
            3'd2: s = {1'b0, a & b};
            3'd3: s = {1'b0, a | b};
            3'd4: s = {1'b0, ~(a | b)};
            3'd5: s = {1'b0, a << b[4:0]};
            3'd6: s = {1'b0, a >> b[4:0]};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Reference: integer arithmetic on whole numbers, returns {result, o, c, n, z}.
    function automatic logic [35:0] ref_model(input op_t x);
        longint          sa, sb, st;
        longint unsigned u;
        logic [31:0]     r;
        logic            o, c;
        o = 1'b0;
        c = 1'b0;
        r = '0;
        case (x.op)
            3'd0: begin
                sa = longint'($signed(x.a));
                sb = longint'($signed(x.b));
                st = x.sub ? sa - sb : sa + sb;
                o  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
                u  = 64'(x.a) + (x.sub ? (64'h1_0000_0000 - 64'(x.b)) : 64'(x.b));
                c  = u[32];
                r  = u[31:0];
            end
            3'd1: r = x.a ^ x.b;
            3'd2: r = x.a & x.b;
            3'd3: r = x.a | x.b;
            3'd4: r = ~(x.a | x.b);
            3'd5: r = x.a << x.b[4:0];
            3'd6: r = x.a >> x.b[4:0];
            default: r = '0;
        endcase
        return {r, o, c, r[31], (r == 32'd0)};
    endfunction

    function automatic logic [31:0] corner(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        case ($urandom_range(0, 7))
            0: r = 32'h0000_0000;
            1: r = 32'h7FFF_FFFF;
            2: r = 32'h8000_0000;
            3: r = 32'hFFFF_FFFF;
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic stim_t known(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                    input logic sub, input logic [31:0] er, input logic [3:0] es);
        stim_t s;
        s.o     = '{a: a, b: b, op: op, sub: sub};
        s.known = 1'b1;
        s.er    = er;
        s.es    = es;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.o.a   = corner($urandom);
        s.o.b   = corner($urandom);
        s.o.op  = 3'($urandom_range(0, 7));
        s.o.sub = 1'($urandom_range(0, 1));
        s.known = 1'b0;
        s.er    = '0;
        s.es    = '0;
        return s;
    endfunction

    // ---------------- EXEC_CYC=1 instance ----------------
    logic        rst_n;
    logic        r0v, r1v;
    stim_t       cur0, cur1;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]  rsp_status;
    logic [2:0]  alu_opcode;
    logic        alu_sub, alu_cin, alu_cout, busy;

    assign {alu_cout, alu_result} = alu_env(alu_a, alu_b, alu_opcode, alu_sub);

    alu_arbiter #(.EXEC_CYC(EC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(req0_ready),
        .req0_a(cur0.o.a), .req0_b(cur0.o.b), .req0_op(cur0.o.op), .req0_sub(cur0.o.sub),
        .req1_valid(r1v), .req1_ready(req1_ready),
        .req1_a(cur1.o.a), .req1_b(cur1.o.b), .req1_op(cur1.o.op), .req1_sub(cur1.o.sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_status(rsp_status),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_sub(alu_sub),
        .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout), .busy(busy)
    );

    // ---------------- EXEC_CYC=3 instance ----------------
    logic        rst3_n;
    logic        d3_v;
    op_t         d3_cur;
    logic        d3_zero_v  = 1'b0;
    op_t         d3_zero_op = '0;
    logic        d3_rr      = 1'b1;
    logic        d3_rdy0, d3_rdy1, d3_rsp0_valid, d3_rsp1_valid;
    logic [31:0] d3_result, d3_alu_a, d3_alu_b, d3_alu_result;
    logic [3:0]  d3_status;
    logic [2:0]  d3_alu_opcode;
    logic        d3_alu_sub, d3_alu_cin, d3_alu_cout, d3_busy;

    assign {d3_alu_cout, d3_alu_result} = alu_env(d3_alu_a, d3_alu_b, d3_alu_opcode, d3_alu_sub);

    alu_arbiter #(.EXEC_CYC(EC3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req0_valid(d3_v), .req0_ready(d3_rdy0),
        .req0_a(d3_cur.a), .req0_b(d3_cur.b), .req0_op(d3_cur.op), .req0_sub(d3_cur.sub),
        .req1_valid(d3_zero_v), .req1_ready(d3_rdy1),
        .req1_a(d3_zero_op.a), .req1_b(d3_zero_op.b), .req1_op(d3_zero_op.op), .req1_sub(d3_zero_op.sub),
        .rsp0_valid(d3_rsp0_valid), .rsp0_ready(d3_rr),
        .rsp1_valid(d3_rsp1_valid), .rsp1_ready(d3_rr),
        .rsp_result(d3_result), .rsp_status(d3_status),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_opcode(d3_alu_opcode), .alu_sub(d3_alu_sub),
        .alu_cin(d3_alu_cin), .alu_result(d3_alu_result), .alu_cout(d3_alu_cout), .busy(d3_busy)
    );

    // ---------------- stimulus queues and drivers ----------------
    stim_t sq0[$];
    stim_t sq1[$];
    bit    dense = 1'b1;
    int    rmode = 0;

    initial begin : drv0
        bit hs;
        r0v  = 1'b0;
        cur0 = '0;
        forever begin
            @(negedge clk);
            hs = r0v && req0_ready;
            @(posedge clk);
            #1;
            if (hs) r0v = 1'b0;
            if (!r0v && sq0.size() != 0 && (dense || $urandom_range(0, 1) == 1)) begin
                cur0 = sq0.pop_front();
                r0v  = 1'b1;
            end
        end
    end

    initial begin : drv1
        bit hs;
        r1v  = 1'b0;
        cur1 = '0;
        forever begin
            @(negedge clk);
            hs = r1v && req1_ready;
            @(posedge clk);
            #1;
            if (hs) r1v = 1'b0;
            if (!r1v && sq1.size() != 0 && (dense || $urandom_range(0, 1) == 1)) begin
                cur1 = sq1.pop_front();
                r1v  = 1'b1;
            end
        end
    end

    initial begin : rsp_drv
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    rsp0_ready = 1'($urandom_range(0, 1));
                    rsp1_ready = 1'($urandom_range(0, 1));
                end
                2: begin
                    rsp0_ready = 1'b0;
                    rsp1_ready = 1'b1;
                end
                default: begin
                    rsp0_ready = 1'b1;
                    rsp1_ready = 1'b1;
                end
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [35:0] exp_q[$];
    int          grants[$];
    bit          pend = 1'b0;
    bit          owner_m = 1'b0;
    bit          lg_m = 1'b1;
    int          acc_cyc = 0;
    int          cyc = 0;

    initial begin : mon
        bit    w0, w1, ev0, ev1, own;
        stim_t s;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("reset_outputs",
                      128'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_status,
                            alu_a, alu_b, alu_opcode, alu_sub, alu_cin, busy}), 128'd0);
                pend = 1'b0;
                lg_m = 1'b1;
                exp_q.delete();
            end else begin
                w1  = r1v && (!r0v || !lg_m);
                w0  = r0v && !w1;
                check("req0_ready", 128'(req0_ready), 128'(!pend && w0));
                check("req1_ready", 128'(req1_ready), 128'(!pend && w1));
                check("busy", 128'(busy), 128'(pend));
                ev0 = pend && !owner_m && (cyc - acc_cyc >= EC + 1);
                ev1 = pend &&  owner_m && (cyc - acc_cyc >= EC + 1);
                check("rsp0_valid", 128'(rsp0_valid), 128'(ev0));
                check("rsp1_valid", 128'(rsp1_valid), 128'(ev1));
                if ((ev0 || ev1) && exp_q.size() != 0) begin
                    check("rsp_result", 128'(rsp_result), 128'(exp_q[0][35:4]));
                    check("rsp_status", 128'(rsp_status), 128'(exp_q[0][3:0]));
                    if ((ev0 && rsp0_ready) || (ev1 && rsp1_ready)) begin
                        void'(exp_q.pop_front());
                        pend = 1'b0;
                    end
                end
                if ((r0v && req0_ready) || (r1v && req1_ready)) begin
                    own = r1v && req1_ready;
                    s   = own ? cur1 : cur0;
                    exp_q.push_back(s.known ? {s.er, s.es} : ref_model(s.o));
                    pend    = 1'b1;
                    owner_m = own;
                    lg_m    = own;
                    acc_cyc = cyc;
                    grants.push_back(int'(own));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    // ---------------- main sequence ----------------
    task automatic drain(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sq0.size() == 0 && sq1.size() == 0 && !r0v && !r1v && !pend) break;
        end
        check("drain_timeout", 128'(n < budget), 128'd1);
    endtask

    task automatic run3(input op_t x, input logic [31:0] er, input logic [3:0] es);
        int n;
        bit ok;
        @(posedge clk);
        #1;
        d3_cur = x;
        d3_v   = 1'b1;
        ok = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (d3_rdy0) begin
                ok = 1'b1;
                break;
            end
        end
        check("d3_first_ready", 128'(ok && n == 0), 128'd1);
        @(posedge clk);
        #1;
        d3_v = 1'b0;
        ok = 1'b0;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (d3_rsp0_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("d3_latency", 128'(n), 128'(EC3 + 1));
        check("d3_result", 128'(d3_result), 128'(er));
        check("d3_status", 128'(d3_status), 128'(es));
        check("d3_rsp1_quiet", 128'(d3_rsp1_valid), 128'd0);
    endtask

    initial begin : main
        bit ok;
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        d3_v   = 1'b0;
        d3_cur = '0;
        sq0.push_back(known(32'd5, 32'd7, 3'b000, 1'b0, 32'd12, 4'b0000));
        sq1.push_back(known(32'd3, 32'd5, 3'b000, 1'b1, 32'hFFFF_FFFE, 4'b0010));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        check("post_reset_req0_ready", 128'({req0_ready, req1_ready}), 128'b10);

        // Continuous contention: grants must alternate.
        sq0.push_back(known(32'h7FFF_FFFF, 32'd1, 3'b000, 1'b0, 32'h8000_0000, 4'b1010));
        sq0.push_back(known(32'h0000_00F0, 32'h0F, 3'b010, 1'b0, 32'd0, 4'b0001));
        sq0.push_back(known(32'd1, 32'd31, 3'b101, 1'b0, 32'h8000_0000, 4'b0010));
        sq1.push_back(known(32'd123, 32'd9, 3'b111, 1'b0, 32'd0, 4'b0001));
        sq1.push_back(known(32'd5, 32'd5, 3'b000, 1'b1, 32'd0, 4'b0101));
        sq1.push_back(known(32'h8000_0000, 32'd4, 3'b110, 1'b0, 32'h0800_0000, 4'b0000));
        drain(200);
        check("rr_grant_count", 128'(grants.size()), 128'd8);
        for (int i = 0; i < 8 && i < grants.size(); i++) begin
            check("rr_grant_order", 128'(grants[i]), 128'(i % 2));
        end

        // Response backpressure on requester 0 while requester 1 waits.
        rmode = 2;
        sq0.push_back(known(32'h0000_000A, 32'h5, 3'b011, 1'b0, 32'h0000_000F, 4'b0000));
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp0_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_rsp_seen", 128'(ok), 128'd1);
        sq1.push_back(known(32'd0, 32'd0, 3'b100, 1'b0, 32'hFFFF_FFFF, 4'b0010));
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_hold", 128'({rsp0_valid, req0_ready, req1_ready}), 128'b100);
        end
        rmode = 0;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_idle", 128'({busy, req1_ready}), 128'b01);
        drain(100);

        // Randomized traffic with random gaps and response stalls.
        dense = 1'b0;
        rmode = 1;
        for (int i = 0; i < 40; i++) begin
            sq0.push_back(rand_stim());
            sq1.push_back(rand_stim());
        end
        drain(4000);
        rmode = 0;

        // EXEC_CYC=3: latency, mid-operation reset, recovery.
        run3('{a: 32'd10, b: 32'd20, op: 3'b000, sub: 1'b0}, 32'd30, 4'b0000);
        @(posedge clk);
        #1;
        d3_cur = '{a: 32'd9, b: 32'd9, op: 3'b000, sub: 1'b0};
        d3_v   = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (d3_rdy0) begin
                ok = 1'b1;
                break;
            end
        end
        check("d3_accept_before_reset", 128'(ok), 128'd1);
        @(posedge clk);
        #1;
        d3_v = 1'b0;
        @(negedge clk);
        check("d3_busy_in_exec", 128'(d3_busy), 128'd1);
        #1;
        rst3_n = 1'b0;
        #1;
        check("d3_async_reset",
              128'({d3_rdy0, d3_rdy1, d3_rsp0_valid, d3_rsp1_valid, d3_result, d3_status,
                    d3_alu_a, d3_alu_b, d3_alu_opcode, d3_alu_sub, d3_alu_cin, d3_busy}), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (d3_rsp0_valid || d3_rsp1_valid || d3_busy) ok = 1'b1;
        end
        check("d3_no_stale_rsp", 128'(ok), 128'd0);
        run3('{a: 32'd1, b: 32'd1, op: 3'b101, sub: 1'b0}, 32'd2, 4'b0000);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
